// File: rtl/addsub_issue_stage.sv
// Issue/collect stage wrapped around the combinational top_level add/sub unit:
// queues commands, drives a/b/select from registers, and returns results in order.
module addsub_issue_stage #(
    parameter int N_BITS = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] in_a,
    input  logic [N_BITS-1:0] in_b,
    input  logic              in_sel,
    output logic [N_BITS-1:0] op_a,
    output logic [N_BITS-1:0] op_b,
    output logic              op_sel,
    input  logic [N_BITS-1:0] alu_out,
    input  logic              alu_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N_BITS-1:0] res_data,
    output logic              res_carry,
    output logic              res_ovf,
    output logic [15:0]       ops_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2*N_BITS:0]     r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [2*N_BITS:0]     w_head;
    logic                  w_sa;
    logic                  w_sb;
    logic                  w_sr;
    logic                  w_ovf;

    assign w_full   = (r_count == FULL_COUNT);
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_head   = r_mem[r_rptr];

    // Overflow is judged from sign bits only; the sum itself comes from top_level.
    assign w_sa  = op_a[N_BITS-1];
    assign w_sb  = op_b[N_BITS-1];
    assign w_sr  = alu_out[N_BITS-1];
    assign w_ovf = op_sel ? ((w_sa != w_sb) && (w_sr != w_sa))
                          : ((w_sa == w_sb) && (w_sr != w_sa));

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = EXEC;
                end
            end
            EXEC: w_next = HOLD;
            HOLD: begin
                if (res_ready) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = EXEC;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Storage is left unreset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_sel, in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
            ops_done  <= '0;
        end else begin
            r_state <= w_next;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                op_sel <= w_head[2*N_BITS];
                op_a   <= w_head[2*N_BITS-1:N_BITS];
                op_b   <= w_head[N_BITS-1:0];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_state == EXEC) begin
                res_valid <= 1'b1;
                res_data  <= alu_out;
                res_carry <= alu_cout;
                res_ovf   <= w_ovf;
            end else if ((r_state == HOLD) && res_ready) begin
                res_valid <= 1'b0;
                ops_done  <= ops_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_addsub_issue_stage.sv
// Directed plus randomized checks of addsub_issue_stage against a queue-based
// model of command order and plain-integer arithmetic for the expected results.
module tb_addsub_issue_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sel;
    logic [31:0] alu_out;
    logic        alu_cout;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_carry;
    logic        res_ovf;
    logic [15:0] ops_done;

    int   testsRun = 0;
    int   testsFailed = 0;
    int   expDone = 0;
    cmd_t cmdQ[$];

    addsub_issue_stage #(.N_BITS(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .alu_out(alu_out), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_ovf(res_ovf),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational top_level unit.
    always_comb begin
        alu_out  = op_sel ? (op_a - op_b) : (op_a + op_b);
        alu_cout = op_sel ? (op_a >= op_b)
                          : ((64'(op_a) + 64'(op_b)) > 64'h0000_0000_FFFF_FFFF);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        assert (got === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        cmd_t        c;
        longint      sa;
        longint      sb;
        longint      r;
        logic [31:0] expData;
        logic        expCarry;
        logic        expOvf;
        if (cmdQ.size() == 0) begin
            chk("unexpectedResult", 32'd1, 32'd0);
            return;
        end
        c  = cmdQ.pop_front();
        sa = longint'($signed(c.a));
        sb = longint'($signed(c.b));
        r  = c.sel ? (sa - sb) : (sa + sb);
        expOvf   = (r != longint'($signed(r[31:0])));
        expData  = c.sel ? (c.a - c.b) : (c.a + c.b);
        expCarry = c.sel ? (c.a >= c.b) : ((64'(c.a) + 64'(c.b)) >> 32) != 64'd0;
        chk("resData", res_data, expData);
        chk("resCarry", 32'(res_carry), 32'(expCarry));
        chk("resOvf", 32'(res_ovf), 32'(expOvf));
    endtask

    // One clock: record accepted command / delivered result, then advance.
    task automatic applyStimulus();
        logic pushed;
        logic popped;
        pushed = in_valid && in_ready;
        popped = res_valid && res_ready;
        if (popped) checkOutput();
        if (pushed) cmdQ.push_back('{a: in_a, b: in_b, sel: in_sel});
        @(posedge clk);
        #1;
        if (popped) begin
            expDone++;
            chk("opsDone", 32'(ops_done), 32'(expDone[15:0]));
        end
    endtask

    task automatic sendOne(input logic [31:0] a, input logic [31:0] b, input logic sel);
        logic acc;
        in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready;
            applyStimulus();
        end
        in_valid = 1'b0;
        if (!acc) chk("sendTimeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (cmdQ.size() == 0 && !res_valid) break;
            applyStimulus();
        end
        chk("drainEmpty", 32'(cmdQ.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        in_a = '0; in_b = '0; in_sel = 1'b0;
        @(posedge clk); #1;
        applyStimulus();
        applyStimulus();
        chk("rstResValid", 32'(res_valid), 32'd0);
        chk("rstOpsDone", 32'(ops_done), 32'd0);
        chk("rstOpA", op_a, 32'd0);
        chk("rstOpB", op_b, 32'd0);
        chk("rstOpSel", 32'(op_sel), 32'd0);
        chk("rstInReady", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Latency of a single add: push at T, op_* after T+1, result after T+2.
        res_ready = 1'b1;
        in_a = 32'd2; in_b = 32'd3; in_sel = 1'b0; in_valid = 1'b1;
        applyStimulus();
        in_valid = 1'b0;
        chk("latT0Valid", 32'(res_valid), 32'd0);
        applyStimulus();
        chk("latT1OpA", op_a, 32'd2);
        chk("latT1OpB", op_b, 32'd3);
        chk("latT1Valid", 32'(res_valid), 32'd0);
        applyStimulus();
        chk("latT2Valid", 32'(res_valid), 32'd1);
        chk("latT2Data", res_data, 32'd5);
        applyStimulus();
        chk("latOpsDone", 32'(ops_done), 32'd1);

        sendOne(32'd3, 32'd2, 1'b1);             drain(20);
        chk("sub32Data", res_data, 32'd1);
        chk("sub32Carry", 32'(res_carry), 32'd1);
        sendOne(32'd2, 32'd3, 1'b1);             drain(20);
        chk("sub23Data", res_data, 32'hFFFF_FFFF);
        chk("sub23Carry", 32'(res_carry), 32'd0);
        sendOne(32'h7FFF_FFFF, 32'd1, 1'b0);     drain(20);
        chk("addOvfData", res_data, 32'h8000_0000);
        chk("addOvf", 32'(res_ovf), 32'd1);
        sendOne(32'h8000_0000, 32'd1, 1'b1);     drain(20);
        chk("subOvfData", res_data, 32'h7FFF_FFFF);
        chk("subOvf", 32'(res_ovf), 32'd1);

        // Back-pressure: one in flight plus four queued, the sixth must stall.
        res_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_a = 32'(k); in_b = 32'(k); in_sel = 1'b0; in_valid = 1'b1;
            chk("fillReady", 32'(in_ready), 32'd1);
            applyStimulus();
        end
        in_a = 32'd6; in_b = 32'd6;
        applyStimulus();
        applyStimulus();
        chk("fullReady", 32'(in_ready), 32'd0);
        chk("fullHeld", res_data, 32'd2);
        res_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = in_ready;
            applyStimulus();
        end
        in_valid = 1'b0;
        chk("sixthAccepted", 32'(acc), 32'd1);
        drain(40);
        chk("burstLast", res_data, 32'd12);
        chk("burstOpsDone", 32'(ops_done), 32'd11);

        // Reset while EXEC with two commands still queued.
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_a = 32'(100 + k); in_b = 32'(k); in_sel = 1'b0; in_valid = 1'b1;
            applyStimulus();
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        cmdQ.delete();
        expDone = 0;
        chk("midRstValid", 32'(res_valid), 32'd0);
        chk("midRstOpsDone", 32'(ops_done), 32'd0);
        chk("midRstReady", 32'(in_ready), 32'd1);
        applyStimulus();
        applyStimulus();
        chk("midRstEmpty", 32'(res_valid), 32'd0);
        chk("midRstOpA", op_a, 32'd0);
        sendOne(32'd9, 32'd4, 1'b1);
        drain(20);
        chk("postRstData", res_data, 32'd5);
        chk("postRstOpsDone", 32'(ops_done), 32'd1);

        // Randomized traffic with corner operands mixed in.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] corner [4];
            corner[0] = 32'h7FFF_FFFF; corner[1] = 32'h8000_0000;
            corner[2] = 32'h0000_0000; corner[3] = 32'hFFFF_FFFF;
            in_valid  = $urandom_range(0, 1) == 1;
            res_ready = $urandom_range(0, 3) != 0;
            in_sel    = $urandom_range(0, 1) == 1;
            in_a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            in_b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            applyStimulus();
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        drain(100);
        chk("randOpsDone", 32'(ops_done), 32'(expDone[15:0]));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
